// File: rtl/aquila_amo_pkg.sv
// aquila_amo_pkg: funct5 encodings, FSM states and helpers shared by the AMO unit
package aquila_amo_pkg;
    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_DONE
    } amo_state_e;

    // True for read-modify-write atomics; LR, SC and unknown codes never write back
    function automatic logic amo_writes(input logic [4:0] f);
        return f inside {F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
                         F5_MIN, F5_MAX, F5_MINU, F5_MAXU};
    endfunction
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational new-value computation f(old, operand, funct5)
module amo_alu
    import aquila_amo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] operand,
    input  logic [4:0]      funct5,
    output logic [XLEN-1:0] result
);
    logic lt_s, lt_u;

    assign lt_s = $signed(old) < $signed(operand);
    assign lt_u = old < operand;

    // Select the value to store back; unknown codes return old unchanged
    always_comb begin
        result = old;
        case (funct5)
            F5_SWAP: result = operand;
            F5_ADD:  result = old + operand;
            F5_XOR:  result = old ^ operand;
            F5_AND:  result = old & operand;
            F5_OR:   result = old | operand;
            F5_MIN:  result = lt_s ? old : operand;
            F5_MAX:  result = lt_s ? operand : old;
            F5_MINU: result = lt_u ? old : operand;
            F5_MAXU: result = lt_u ? operand : old;
            default: result = old;
        endcase
    end
endmodule

// File: rtl/amo_exec_unit.sv
// amo_exec_unit: executes loads, stores, LR/SC and AMOs against memory with per-core reservations
`ifndef CORE_NUMS
`define CORE_NUMS 4
`endif
module amo_exec_unit
    import aquila_amo_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int CORE_NUMS      = `CORE_NUMS,
    parameter int CORE_NUMS_BITS = (CORE_NUMS == 1) ? 1 : $clog2(CORE_NUMS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CORE_NUMS_BITS-1:0] AMO_id_i,
    input  logic                      AMO_strobe_i,
    input  logic [XLEN-1:0]           AMO_addr_i,
    input  logic                      AMO_rw_i,
    input  logic [XLEN-1:0]           AMO_data_i,
    input  logic                      AMO_is_amo_i,
    input  logic [4:0]                AMO_amo_type_i,
    output logic                      AMO_data_ready_o,
    output logic [XLEN-1:0]           AMO_data_o,
    output logic                      M_strobe_o,
    output logic [XLEN-1:0]           M_addr_o,
    output logic                      M_rw_o,
    output logic [XLEN-1:0]           M_data_o,
    input  logic [XLEN-1:0]           M_data_i,
    input  logic                      M_ready_i,
    input  logic                      inv_strobe_i,
    input  logic [XLEN-1:0]           inv_addr_i
);
    amo_state_e                state;
    logic [CORE_NUMS_BITS-1:0] id_q;
    logic [XLEN-1:0]           data_q;
    logic [4:0]                type_q;
    logic                      rw_q, amo_q;
    logic [CORE_NUMS-1:0]      rsv_valid;
    logic [XLEN-1:0]           rsv_word [CORE_NUMS];
    logic [XLEN-1:0]           alu_out, cur_word, inv_word;
    logic                      is_sc, is_lr, need_read, inv_hit, sc_ok, lr_set, wr_done, sc_clr;

    // Words are compared as address >> 2 so the byte offset never matters
    assign cur_word  = M_addr_o >> 2;
    assign inv_word  = inv_addr_i >> 2;
    assign is_sc     = amo_q && type_q == F5_SC;
    assign is_lr     = amo_q && type_q == F5_LR;
    assign need_read = amo_q ? !is_sc : !rw_q;
    assign inv_hit   = inv_strobe_i && inv_word == cur_word;
    assign sc_ok     = rsv_valid[id_q] && rsv_word[id_q] == cur_word && !inv_hit;
    assign lr_set    = state == S_RD_WAIT && M_ready_i && is_lr;
    assign wr_done   = state == S_WR_WAIT && M_ready_i;
    assign sc_clr    = state == S_RD && is_sc;

    assign M_strobe_o       = (state == S_RD && need_read) || state == S_WR;
    assign AMO_data_ready_o = state == S_DONE;

    amo_alu #(.XLEN(XLEN)) u_alu (
        .old     (M_data_i),
        .operand (data_q),
        .funct5  (type_q),
        .result  (alu_out)
    );

    // Request sequencing: S_RD either reads or, for stores and SC, decides the write directly
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            id_q       <= '0;
            data_q     <= '0;
            type_q     <= '0;
            rw_q       <= 1'b0;
            amo_q      <= 1'b0;
            M_addr_o   <= '0;
            M_rw_o     <= 1'b0;
            M_data_o   <= '0;
            AMO_data_o <= '0;
        end else begin
            case (state)
                S_IDLE: if (AMO_strobe_i) begin
                    state    <= S_RD;
                    id_q     <= AMO_id_i;
                    data_q   <= AMO_data_i;
                    type_q   <= AMO_amo_type_i;
                    rw_q     <= AMO_rw_i;
                    amo_q    <= AMO_is_amo_i;
                    M_addr_o <= AMO_addr_i;
                    M_rw_o   <= 1'b0;
                end
                S_RD: begin
                    state      <= need_read ? S_RD_WAIT : (is_sc && !sc_ok) ? S_DONE : S_WR;
                    M_rw_o     <= !need_read && (!is_sc || sc_ok);
                    M_data_o   <= data_q;
                    AMO_data_o <= {{(XLEN-1){1'b0}}, is_sc && !sc_ok};
                end
                S_RD_WAIT: if (M_ready_i) begin
                    state      <= (amo_q && amo_writes(type_q)) ? S_WR : S_DONE;
                    M_rw_o     <= amo_q && amo_writes(type_q);
                    M_data_o   <= alu_out;
                    AMO_data_o <= M_data_i;
                end
                S_WR:      state <= S_WR_WAIT;
                S_WR_WAIT: if (M_ready_i) state <= S_DONE;
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Reservations: LR sets (unless invalidated the same cycle); SC, own writes and snoops clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsv_valid <= '0;
        end else begin
            for (int i = 0; i < CORE_NUMS; i++) begin
                if (lr_set && id_q == CORE_NUMS_BITS'(i)) begin
                    rsv_valid[i] <= !inv_hit;
                    rsv_word[i]  <= cur_word;
                end else if ((inv_strobe_i && rsv_word[i] == inv_word) ||
                             (wr_done && rsv_word[i] == cur_word) ||
                             (sc_clr && id_q == CORE_NUMS_BITS'(i))) begin
                    rsv_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_amo_exec_unit.sv
// tb_amo_exec_unit: scoreboard bench with a behavioural memory and reference AMO model
module tb_amo_exec_unit;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  AMO_id_i = '0;
    logic        AMO_strobe_i = 1'b0;
    logic [31:0] AMO_addr_i = '0;
    logic        AMO_rw_i = 1'b0;
    logic [31:0] AMO_data_i = '0;
    logic        AMO_is_amo_i = 1'b0;
    logic [4:0]  AMO_amo_type_i = '0;
    logic        AMO_data_ready_o;
    logic [31:0] AMO_data_o;
    logic        M_strobe_o;
    logic [31:0] M_addr_o;
    logic        M_rw_o;
    logic [31:0] M_data_o;
    logic [31:0] M_data_i;
    logic        M_ready_i;
    logic        inv_strobe_i = 1'b0;
    logic [31:0] inv_addr_i = '0;

    int n_chk = 0, n_fail = 0, ready_cnt = 0, strobe_cnt = 0, mem_lat = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    amo_exec_unit #(.XLEN(32), .CORE_NUMS(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .AMO_id_i(AMO_id_i), .AMO_strobe_i(AMO_strobe_i),
        .AMO_addr_i(AMO_addr_i), .AMO_rw_i(AMO_rw_i), .AMO_data_i(AMO_data_i),
        .AMO_is_amo_i(AMO_is_amo_i), .AMO_amo_type_i(AMO_amo_type_i),
        .AMO_data_ready_o(AMO_data_ready_o), .AMO_data_o(AMO_data_o),
        .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o), .M_rw_o(M_rw_o), .M_data_o(M_data_o),
        .M_data_i(M_data_i), .M_ready_i(M_ready_i),
        .inv_strobe_i(inv_strobe_i), .inv_addr_i(inv_addr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_f(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            5'b00001: return b;
            5'b00000: return a + b;
            5'b00100: return a ^ b;
            5'b01100: return a & b;
            5'b01000: return a | b;
            5'b10000: return ($signed(a) < $signed(b)) ? a : b;
            5'b10100: return ($signed(a) > $signed(b)) ? a : b;
            5'b11000: return (a < b) ? a : b;
            5'b11100: return (a > b) ? a : b;
            default:  return a;
        endcase
    endfunction

    // Scoreboard: every completion pops the oldest expected result
    always @(negedge clk) begin
        if (M_strobe_o) strobe_cnt++;
        if (AMO_data_ready_o) begin
            ready_cnt++;
            if (exp_q.size() == 0) check("unexpected_ready", AMO_data_o, 32'hDEAD_BEEF);
            else check("result", AMO_data_o, exp_q.pop_front());
        end
    end

    // Memory: latches a strobed request, answers after 1..3 cycles (or mem_lat when set)
    initial begin : memory
        logic [31:0] a, d;
        logic w;
        int l;
        M_ready_i = 1'b0;
        M_data_i = '0;
        forever begin
            @(negedge clk);
            if (M_strobe_o) begin
                a = M_addr_o; d = M_data_o; w = M_rw_o;
                l = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 3));
                repeat (l) @(posedge clk);
                #1 M_ready_i = 1'b1;
                M_data_i = rd(a);
                if (w) mem[a[31:2]] = d;
                @(posedge clk);
                #1 M_ready_i = 1'b0;
            end
        end
    end

    task automatic req(input int id, input logic [31:0] addr, input logic amo, input logic [4:0] f,
                       input logic rw, input logic [31:0] d, input logic [31:0] exp, output int cyc);
        exp_q.push_back(exp);
        AMO_id_i = id[1:0]; AMO_addr_i = addr; AMO_is_amo_i = amo; AMO_amo_type_i = f;
        AMO_rw_i = rw; AMO_data_i = d; AMO_strobe_i = 1'b1;
        @(posedge clk); #1 AMO_strobe_i = 1'b0;
        cyc = 1;
        while (!AMO_data_ready_o && cyc < 100) begin
            @(posedge clk); #1 cyc++;
        end
        check("done", {31'b0, AMO_data_ready_o}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic inv(input logic [31:0] a);
        inv_strobe_i = 1'b1; inv_addr_i = a;
        @(posedge clk); #1 inv_strobe_i = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_strobe"}, {31'b0, M_strobe_o}, 0);
        check({tag, "_ready"}, {31'b0, AMO_data_ready_o}, 0);
        check({tag, "_data"}, AMO_data_o, 0);
        check({tag, "_maddr"}, M_addr_o, 0);
        check({tag, "_mrw"}, {31'b0, M_rw_o}, 0);
        check({tag, "_mdata"}, M_data_o, 0);
    endtask

    initial begin
        int cyc, rc, sc, t, k;
        logic [4:0] ops [9] = '{5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
                                 5'b10000, 5'b10100, 5'b11000, 5'b11100};
        logic [31:0] a, d, old;
        logic [4:0] f;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        #1 rst_i = 1'b0;
        @(posedge clk); #1;

        // Plain AMOADD
        mem[30'h40] = 32'd5;
        rc = ready_cnt;
        req(0, 32'h100, 1, 5'b00000, 0, 32'd3, 32'd5, cyc);
        check("add_mem", rd(32'h100), 32'd8);
        check("add_ready_once", ready_cnt - rc, 1);

        // Successful LR/SC on core 1
        mem[30'h80] = 32'h11;
        req(1, 32'h200, 1, 5'b00010, 0, 0, 32'h11, cyc);
        req(1, 32'h200, 1, 5'b00011, 0, 32'hAB, 32'd0, cyc);
        check("sc_ok_mem", rd(32'h200), 32'hAB);

        // Foreign store to the neighbour word is harmless, to the same word kills the SC
        req(0, 32'h200, 1, 5'b00010, 0, 0, 32'hAB, cyc);
        inv(32'h204);
        inv(32'h200);
        sc = strobe_cnt;
        req(0, 32'h200, 1, 5'b00011, 0, 32'h55, 32'd1, cyc);
        check("sc_fail_no_strobe", strobe_cnt - sc, 0);
        check("sc_fail_latency", cyc, 2);
        check("sc_fail_mem", rd(32'h200), 32'hAB);
        req(0, 32'h200, 1, 5'b00010, 0, 0, 32'hAB, cyc);
        inv(32'h204);
        req(0, 32'h200, 1, 5'b00011, 0, 32'h77, 32'd0, cyc);
        check("sc_neighbour_mem", rd(32'h200), 32'h77);

        // Signed versus unsigned minimum
        mem[30'h100] = 32'hFFFF_FFFF;
        req(0, 32'h400, 1, 5'b10000, 0, 32'd1, 32'hFFFF_FFFF, cyc);
        check("min_mem", rd(32'h400), 32'hFFFF_FFFF);
        req(0, 32'h400, 1, 5'b11000, 0, 32'd1, 32'hFFFF_FFFF, cyc);
        check("minu_mem", rd(32'h400), 32'd1);

        // Cross-core invalidation by an AMOSWAP
        mem[30'hC0] = 32'h10;
        req(0, 32'h300, 1, 5'b00010, 0, 0, 32'h10, cyc);
        req(2, 32'h300, 1, 5'b00010, 0, 0, 32'h10, cyc);
        req(2, 32'h300, 1, 5'b00001, 0, 32'h99, 32'h10, cyc);
        req(0, 32'h300, 1, 5'b00011, 0, 32'd5, 32'd1, cyc);
        req(2, 32'h300, 1, 5'b00011, 0, 32'd6, 32'd1, cyc);
        check("swap_mem", rd(32'h300), 32'h99);

        // Reset while waiting for a write to complete
        mem[30'h140] = 32'h22;
        req(1, 32'h500, 1, 5'b00010, 0, 0, 32'h22, cyc);
        mem_lat = 4;
        AMO_id_i = 2'd1; AMO_addr_i = 32'h500; AMO_is_amo_i = 1; AMO_amo_type_i = 5'b00000;
        AMO_data_i = 32'd1; AMO_strobe_i = 1'b1;
        @(posedge clk); #1 AMO_strobe_i = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!(M_strobe_o && M_rw_o) && t < 50);
        check("wr_strobe_seen", {31'b0, M_strobe_o && M_rw_o}, 1);
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("midrst");
        rst_i = 1'b0;
        rc = ready_cnt;
        repeat (8) @(posedge clk);
        #1 check("midrst_no_ready", ready_cnt - rc, 0);
        mem_lat = 0;
        req(1, 32'h500, 1, 5'b00011, 0, 32'h33, 32'd1, cyc);
        mem[30'h180] = 32'd40;
        req(3, 32'h600, 1, 5'b00000, 0, 32'd2, 32'd40, cyc);
        check("post_rst_mem", rd(32'h600), 32'd42);

        // Random mix of AMOs, plain accesses and an unknown funct5 against a reference memory
        for (int i = 0; i < 4; i++) begin
            mem[30'h1C0 + 30'(i)] = $urandom;
            ref_mem[30'h1C0 + 30'(i)] = mem[30'h1C0 + 30'(i)];
        end
        for (int i = 0; i < 30; i++) begin
            a = 32'h700 + 32'($urandom_range(0, 3)) * 4;
            d = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
            old = ref_mem[a[31:2]];
            k = $urandom_range(0, 11);
            f = (k < 9) ? ops[k] : 5'b00101;
            if (k < 9) begin
                ref_mem[a[31:2]] = ref_f(f, old, d);
                req(i % 4, a, 1, f, 0, d, old, cyc);
            end else if (k == 9) begin
                req(i % 4, a, 0, f, 0, d, old, cyc);
            end else if (k == 10) begin
                ref_mem[a[31:2]] = d;
                req(i % 4, a, 0, f, 1, d, 32'd0, cyc);
            end else begin
                req(i % 4, a, 1, f, 0, d, old, cyc);
            end
        end
        for (int i = 0; i < 4; i++)
            check("rand_mem", rd(32'h700 + 32'(i) * 4), ref_mem[30'h1C0 + 30'(i)]);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
